mhq: RTL and testbench

MHQ -- requirements
Module: mhq

---
 rtl/mhq.sv | 198 +++++++++++++++++++
 tb/tb_mhq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mhq.sv
// Miss handling queue: FIFO of line misses, one memory read at a time, store merge, fill broadcast; fill_en one cycle after ccu_done.
// Full or a head-in-FILL conflict returns retry; optional store merge into an existing entry is enabled by MHQ_STORE_MERGE_EN.
module mhq #(
    parameter int MHQ_DEPTH    = 4,
    parameter int DC_LINE_SIZE = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_lookup_valid,
    input  logic                              i_lookup_dc_hit,
    input  logic [31:0]                       i_lookup_addr,
    input  logic [3:0]                        i_lookup_lsu_func,
    input  logic [31:0]                       i_lookup_data,
    input  logic                              i_lookup_we,
    output logic                              o_lookup_retry,
    output logic [$clog2(MHQ_DEPTH)-1:0]      o_lookup_tag,
    output logic                              o_fill_en,
    output logic [31:0]                       o_fill_addr,
    output logic [$clog2(MHQ_DEPTH)-1:0]      o_fill_tag,
    output logic [8*DC_LINE_SIZE-1:0]         o_fill_data,
    output logic                              o_fill_dirty,
    output logic                              o_ccu_en,
    output logic [31:0]                       o_ccu_addr,
    input  logic                              i_ccu_done,
    input  logic [8*DC_LINE_SIZE-1:0]         i_ccu_data
);
    localparam int IW = $clog2(MHQ_DEPTH);
    localparam int OW = $clog2(DC_LINE_SIZE);
    localparam int LW = 8 * DC_LINE_SIZE;
    localparam int AW = 32 - OW;

`ifdef MHQ_STORE_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t state, state_nxt;

    logic [MHQ_DEPTH-1:0]    ent_vld;
    logic [MHQ_DEPTH-1:0]    ent_dirty;
    logic [AW-1:0]           ent_line [MHQ_DEPTH];
    logic [LW-1:0]           ent_data [MHQ_DEPTH];
    logic [DC_LINE_SIZE-1:0] ent_mask [MHQ_DEPTH];

    logic [IW:0]   head, tail;
    logic [IW-1:0] head_idx, tail_idx;
    logic          full;

    logic          miss, match, acc, alloc, wr;
    logic [IW-1:0] match_idx;
    logic [AW-1:0] lk_line;
    logic [OW-1:0] lk_off;
    logic [3:0]    lanes;
    logic [DC_LINE_SIZE-1:0] st_mask;
    logic [LW-1:0]           st_data;

    logic          hd_merge, hd_dirty;
    logic [LW-1:0] fill_line;
    logic          unused_func;

    assign head_idx    = head[IW-1:0];
    assign tail_idx    = tail[IW-1:0];
    assign full        = (head_idx == tail_idx) && (head[IW] != tail[IW]);
    assign miss        = i_lookup_valid && !i_lookup_dc_hit;
    assign lk_line     = i_lookup_addr[31:OW];
    assign lk_off      = i_lookup_addr[OW-1:0];
    assign unused_func = ^i_lookup_lsu_func[3:2];

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < MHQ_DEPTH; i++) begin
            if (ent_vld[i] && (ent_line[i] == lk_line)) begin
                match     = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_comb begin
        o_lookup_retry = 1'b0;
        o_lookup_tag   = '0;
        if (miss) begin
            if (match) begin
                o_lookup_tag = match_idx;
                // The head line is being broadcast; a merge now would be lost.
                if ((state == S_FILL) && (match_idx == head_idx)) o_lookup_retry = 1'b1;
                if (i_lookup_we && !MERGE_EN)                     o_lookup_retry = 1'b1;
            end else if (full) begin
                o_lookup_retry = 1'b1;
            end else begin
                o_lookup_tag = tail_idx;
            end
        end
    end

    assign acc   = miss && !o_lookup_retry;
    assign alloc = acc && !match;
    assign wr    = acc && i_lookup_we;

    always_comb begin
        case (i_lookup_lsu_func[1:0])
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    assign st_mask = DC_LINE_SIZE'(lanes) << lk_off;
    assign st_data = LW'(i_lookup_data) << {lk_off, 3'b000};

    // A store landing on the head in the done cycle must reach the latched line.
    assign hd_merge = wr && (o_lookup_tag == head_idx);
    assign hd_dirty = ent_dirty[head_idx] || hd_merge;

    always_comb begin
        fill_line = i_ccu_data;
        for (int b = 0; b < DC_LINE_SIZE; b++) begin
            if (hd_merge && st_mask[b])
                fill_line[b*8 +: 8] = st_data[b*8 +: 8];
            else if (ent_mask[head_idx][b])
                fill_line[b*8 +: 8] = ent_data[head_idx][b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ent_vld[head_idx]) state_nxt = S_REQ;
            S_REQ:   if (i_ccu_done)        state_nxt = S_FILL;
            S_FILL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ccu_en  = (state == S_REQ);
        o_fill_en = (state == S_FILL);
    end

    assign o_ccu_addr = {ent_line[head_idx], {OW{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld   <= '0;
            ent_dirty <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            if (alloc) begin
                ent_vld[tail_idx]   <= 1'b1;
                ent_line[tail_idx]  <= lk_line;
                ent_dirty[tail_idx] <= i_lookup_we;
                tail                <= tail + 1'b1;
            end else if (wr) begin
                ent_dirty[match_idx] <= 1'b1;
            end
            if (state == S_FILL) begin
                ent_vld[head_idx] <= 1'b0;
                head              <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            ent_mask[tail_idx] <= i_lookup_we ? st_mask : '0;
        else if (wr)
            ent_mask[match_idx] <= ent_mask[match_idx] | st_mask;
        if (wr) begin
            for (int b = 0; b < DC_LINE_SIZE; b++) begin
                if (st_mask[b]) ent_data[o_lookup_tag][b*8 +: 8] <= st_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_fill_addr  <= '0;
            o_fill_tag   <= '0;
            o_fill_data  <= '0;
            o_fill_dirty <= 1'b0;
        end else if ((state == S_REQ) && i_ccu_done) begin
            o_fill_addr  <= o_ccu_addr;
            o_fill_tag   <= head_idx;
            o_fill_data  <= fill_line;
            o_fill_dirty <= hd_dirty;
        end
    end
endmodule

// File: tb/tb_mhq.sv
// Directed bench for mhq: lookups push expected fills to a scoreboard, fills pop and compare.
module tb_mhq;
`ifdef MHQ_STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_lookup_valid = 1'b0;
    logic         i_lookup_dc_hit = 1'b0;
    logic [31:0]  i_lookup_addr = '0;
    logic [3:0]   i_lookup_lsu_func = '0;
    logic [31:0]  i_lookup_data = '0;
    logic         i_lookup_we = 1'b0;
    logic         o_lookup_retry;
    logic [1:0]   o_lookup_tag;
    logic         o_fill_en;
    logic [31:0]  o_fill_addr;
    logic [1:0]   o_fill_tag;
    logic [255:0] o_fill_data;
    logic         o_fill_dirty;
    logic         o_ccu_en;
    logic [31:0]  o_ccu_addr;
    logic         i_ccu_done = 1'b0;
    logic [255:0] i_ccu_data = '0;

    mhq dut (
        .clk(clk), .rst(rst),
        .i_lookup_valid(i_lookup_valid), .i_lookup_dc_hit(i_lookup_dc_hit),
        .i_lookup_addr(i_lookup_addr), .i_lookup_lsu_func(i_lookup_lsu_func),
        .i_lookup_data(i_lookup_data), .i_lookup_we(i_lookup_we),
        .o_lookup_retry(o_lookup_retry), .o_lookup_tag(o_lookup_tag),
        .o_fill_en(o_fill_en), .o_fill_addr(o_fill_addr), .o_fill_tag(o_fill_tag),
        .o_fill_data(o_fill_data), .o_fill_dirty(o_fill_dirty),
        .o_ccu_en(o_ccu_en), .o_ccu_addr(o_ccu_addr),
        .i_ccu_done(i_ccu_done), .i_ccu_data(i_ccu_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   tag;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [31:0]  mask;
        logic         dirty;
    } sb_t;

    sb_t          sb[$];
    logic [255:0] mem_line;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input int seed);
        logic [255:0] l;
        for (int b = 0; b < 32; b++) l[b*8 +: 8] = 8'(seed * 37 + b * 5 + 1);
        return l;
    endfunction

    // Model of an accepted miss: allocate a new expected fill or merge store bytes into it.
    task automatic sb_apply(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input logic we, input logic [1:0] tag);
        int  idx = -1;
        sb_t e;
        for (int i = 0; i < sb.size(); i++) if (sb[i].addr == {a[31:5], 5'd0}) idx = i;
        if (idx < 0) begin
            e.tag = tag; e.addr = {a[31:5], 5'd0}; e.data = '0; e.mask = '0; e.dirty = 1'b0;
            sb.push_back(e);
            idx = sb.size() - 1;
        end
        e = sb[idx];
        if (we) begin
            for (int k = 0; k < (1 << sz); k++) begin
                e.data[(a[4:0] + k) * 8 +: 8] = d[k*8 +: 8];
                e.mask[a[4:0] + k] = 1'b1;
            end
            e.dirty = 1'b1;
        end
        sb[idx] = e;
    endtask

    task automatic lookup(input logic hit, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input logic we, input logic exp_retry,
                          input logic [1:0] exp_tag, input bit ck_tag, input string nm);
        i_lookup_valid = 1'b1; i_lookup_dc_hit = hit; i_lookup_addr = a;
        i_lookup_lsu_func = {2'b00, sz}; i_lookup_data = d; i_lookup_we = we;
        @(negedge clk);
        chk({nm, " retry"}, o_lookup_retry, exp_retry);
        if (ck_tag) chk({nm, " tag"}, o_lookup_tag, exp_tag);
        if (!hit && !exp_retry) sb_apply(a, sz, d, we, exp_tag);
        @(posedge clk); #1;
        i_lookup_valid = 1'b0; i_lookup_dc_hit = 1'b0; i_lookup_we = 1'b0;
    endtask

    task automatic wait_ccu(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (o_ccu_en) seen = 1'b1;
        end
        chk("ccu_en raised", seen, 1'b1);
    endtask

    // Answer the outstanding request; optionally drive a byte store in the done cycle.
    task automatic serve(input logic [31:0] a, input int seed, input bit st,
                         input logic [31:0] sa, input logic [7:0] sd, input logic st_retry);
        bit seen;
        wait_ccu(seen);
        chk("ccu_addr", o_ccu_addr, a);
        mem_line   = mk_line(seed);
        i_ccu_data = mem_line;
        i_ccu_done = 1'b1;
        if (st) begin
            i_lookup_valid = 1'b1; i_lookup_dc_hit = 1'b0; i_lookup_addr = sa;
            i_lookup_lsu_func = 4'b0000; i_lookup_data = {24'd0, sd}; i_lookup_we = 1'b1;
            #1;
            chk("done-cycle store retry", o_lookup_retry, st_retry);
            if (!st_retry) begin
                chk("done-cycle store tag", o_lookup_tag, 2'd0);
                sb_apply(sa, 2'b00, {24'd0, sd}, 1'b1, 2'd0);
            end
        end
        @(posedge clk); #1;
        i_ccu_done = 1'b0; i_lookup_valid = 1'b0; i_lookup_we = 1'b0;
    endtask

    task automatic check_fill(input string nm);
        sb_t          e;
        logic [255:0] exp_d;
        @(negedge clk);
        chk({nm, " fill_en"}, o_fill_en, 1'b1);
        chk({nm, " scoreboard entry"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int b = 0; b < 32; b++)
                exp_d[b*8 +: 8] = e.mask[b] ? e.data[b*8 +: 8] : mem_line[b*8 +: 8];
            chk({nm, " fill_tag"},   o_fill_tag,   e.tag);
            chk({nm, " fill_addr"},  o_fill_addr,  e.addr);
            chk({nm, " fill_data"},  o_fill_data,  exp_d);
            chk({nm, " fill_dirty"}, o_fill_dirty, e.dirty);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " fill_en one cycle"}, o_fill_en, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst fill_en",    o_fill_en,    1'b0);
        chk("rst ccu_en",     o_ccu_en,     1'b0);
        chk("rst fill_data",  o_fill_data,  256'd0);
        chk("rst fill_addr",  o_fill_addr,  32'd0);
        chk("rst fill_tag",   o_fill_tag,   2'd0);
        chk("rst fill_dirty", o_fill_dirty, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post-rst retry", o_lookup_retry, 1'b0);
        chk("post-rst tag",   o_lookup_tag,   2'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        do_reset();

        // Hit needs no handling.
        lookup(1'b1, 32'h0000_1234, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "hit");

        // Load miss into empty queue.
        lookup(1'b0, 32'h0000_1004, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "load 1004");
        serve(32'h0000_1000, 1, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 1000");

        // Store allocates, later load matches.
        do_reset();
        lookup(1'b0, 32'h0000_2008, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 1'b1, "store 2008");
        lookup(1'b0, 32'h0000_2010, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "load 2010");
        serve(32'h0000_2000, 2, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 2000");

        // Fill the queue, overflow, wrap.
        do_reset();
        lookup(1'b0, 32'h0000_4000, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "miss 4000");
        lookup(1'b0, 32'h0000_4040, 2'b01, 32'h0, 1'b0, 1'b0, 2'd1, 1'b1, "miss 4040");
        lookup(1'b0, 32'h0000_4080, 2'b10, 32'h0, 1'b0, 1'b0, 2'd2, 1'b1, "miss 4080");
        lookup(1'b0, 32'h0000_40C0, 2'b00, 32'h0, 1'b0, 1'b0, 2'd3, 1'b1, "miss 40C0");
        lookup(1'b0, 32'h0000_4048, 2'b10, 32'h0, 1'b0, 1'b0, 2'd1, 1'b1, "load match 4040");
        if (MERGE)
            lookup(1'b0, 32'h0000_4082, 2'b01, 32'h0000_A577, 1'b1, 1'b0, 2'd2, 1'b1, "store merge 4080");
        else
            lookup(1'b0, 32'h0000_4082, 2'b01, 32'h0000_A577, 1'b1, 1'b1, 2'd0, 1'b0, "store match retry");
        lookup(1'b0, 32'h0000_5000, 2'b10, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, "full retry");
        serve(32'h0000_4000, 3, 1'b0, 32'h0, 8'h0, 1'b0);
        fork
            lookup(1'b0, 32'h0000_5004, 2'b10, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, "full during dequeue");
            check_fill("fill 4000");
        join
        lookup(1'b0, 32'h0000_5000, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "wrap alloc 5000");
        serve(32'h0000_4040, 4, 1'b0, 32'h0, 8'h0, 1'b0);
        fork
            lookup(1'b0, 32'h0000_4044, 2'b10, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, "head in fill");
            check_fill("fill 4040");
        join
        serve(32'h0000_4080, 5, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 4080");
        serve(32'h0000_40C0, 6, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 40C0");
        serve(32'h0000_5000, 7, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 5000 wrapped");

        // Store merge in the ccu_done cycle.
        do_reset();
        lookup(1'b0, 32'h0000_3000, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "load 3000");
        serve(32'h0000_3000, 8, 1'b1, 32'h0000_3001, 8'h55, !MERGE);
        check_fill("fill 3000");

        // Reset abandons an in-flight request.
        do_reset();
        lookup(1'b0, 32'h0000_6000, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "miss 6000");
        wait_ccu(seen);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        i_ccu_data = mk_line(9);
        i_ccu_done = 1'b1;
        @(posedge clk); #1;
        i_ccu_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abandoned fill_en", o_fill_en, 1'b0);
            chk("abandoned ccu_en",  o_ccu_en,  1'b0);
        end
        @(posedge clk); #1;
        lookup(1'b0, 32'h0000_7000, 2'b10, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, "miss 7000 after rst");
        serve(32'h0000_7000, 10, 1'b0, 32'h0, 8'h0, 1'b0);
        check_fill("fill 7000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
